fsl_block_accel: RTL and testbench
==================================

FSL_BLOCK_ACCEL -- requirements
Module: fsl_block_accel

Interface
REQ-001 Parameter C_DWIDTH, default 32, FSL data word width in bits (8..64).
REQ-002 Parameter C_BLOCK_WORDS, default 4, words per block; power of two, 2..16.
REQ-003 FSL_Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 FSL_Rst  input  1  reset, synchronous, active-high.
REQ-005 FSL_S_Clk  output  1  driven by FSL_Clk.
REQ-006 FSL_S_Read  output  1  consume current slave word this cycle.
REQ-007 FSL_S_Data  input  [0:C_DWIDTH-1]  slave data word.
REQ-008 FSL_S_Control  input  1  1 = key word, 0 = data word.
REQ-009 FSL_S_Exists  input  1  slave word available.
REQ-010 FSL_M_Clk  output  1  driven by FSL_Clk.
REQ-011 FSL_M_Write  output  1  push FSL_M_Data to master FIFO this cycle.
REQ-012 FSL_M_Data  output  [0:C_DWIDTH-1]  result word.
REQ-013 FSL_M_Control  output  1  high on last word of each output block only.
REQ-014 FSL_M_Full  input  1  master FIFO full; no write permitted.

Function
REQ-015 The block SHALL implement two states, COLLECT and EMIT; it SHALL enter COLLECT out of reset.
REQ-016 In COLLECT, FSL_S_Read SHALL equal FSL_S_Exists combinationally; FSL_M_Write SHALL be 0.
REQ-017 A consumed word with FSL_S_Control=1 SHALL be written to key[kidx]; kidx SHALL increment modulo C_BLOCK_WORDS; widx SHALL be unchanged.
REQ-018 A consumed word with FSL_S_Control=0 SHALL store buf[widx] = data XOR key[widx], using the key contents before any same-cycle update; widx SHALL then increment.
REQ-019 Consuming the data word at widx = C_BLOCK_WORDS-1 SHALL wrap widx to 0 and move to EMIT on the next cycle.
REQ-020 In EMIT, FSL_S_Read SHALL be 0, FSL_M_Write SHALL equal NOT FSL_M_Full, and FSL_M_Data SHALL equal buf[ridx].
REQ-021 ridx SHALL advance only on a cycle with FSL_M_Write=1; FSL_M_Data SHALL hold stable while FSL_M_Full=1.
REQ-022 FSL_M_Control SHALL be 1 exactly when in EMIT and ridx = C_BLOCK_WORDS-1.
REQ-023 Writing the word at ridx = C_BLOCK_WORDS-1 SHALL wrap ridx to 0 and return to COLLECT on the next cycle.
REQ-024 The first output word SHALL be presented one cycle after the last data word of a block is consumed; peak throughput SHALL be one word per cycle per direction.
REQ-025 Key words arriving mid-block SHALL take effect only for data words consumed in later cycles.

Reset
REQ-026 While FSL_Rst=1: state=COLLECT; widx, ridx, kidx = 0; all key and buf entries = 0; FSL_S_Read, FSL_M_Write, and FSL_M_Control = 0.
REQ-027 Reset asserted mid-block or mid-EMIT SHALL discard the partial block; no further output words SHALL be written.

Configuration
REQ-028 Macro FSL_BLOCK_ACCEL_CHAIN_EN SHALL, when defined, add a chain register chain[0..C_BLOCK_WORDS-1] (reset 0).
REQ-029 With the macro defined, REQ-018 SHALL store data XOR key[widx] XOR chain[widx].
REQ-030 With the macro defined, chain SHALL load the full buf on the cycle the last word is written (REQ-023).
REQ-031 With the macro defined, any key-word write SHALL clear all chain entries to 0.
REQ-032 Without the macro, no chain storage SHALL exist, and the output SHALL be data XOR key only.

Verification (C_DWIDTH=32, C_BLOCK_WORDS=4)
REQ-033 Scenario 1: keys 0x1,0x2,0x3,0x4, then data 0x10,0x20,0x30,0x40 -> outputs 0x11,0x22,0x33,0x44; FSL_M_Control=1 on 0x44 only.
REQ-034 Scenario 2: FSL_M_Full=1 for 5 cycles after the first output word -> FSL_M_Write=0 and FSL_M_Data stable throughout; FSL_S_Read=0; the remaining 3 words follow in order once Full drops.
REQ-035 Scenario 3: FSL_S_Exists=1 continuously across the EMIT boundary -> no word consumed during EMIT; the next block starts on the cycle after its last write.
REQ-036 Scenario 4: zero keys; data A,B; key 0xFF (control=1); data C,D -> outputs A,B,C,D; the next block's word 0 equals data XOR 0xFF.
REQ-037 Scenario 5 (CHAIN_EN): zero keys; two blocks both 0x1,0x2,0x3,0x4 -> second output block is 0,0,0,0; a key write, then the same block -> 0x1,0x2,0x3,0x4.
REQ-038 Scenario 6: FSL_Rst pulsed after 2 of 4 outputs -> FSL_M_Write=0 from the next cycle; the next 4 data words are output as XOR with zero keys.

Source files
------------

// File: rtl/fsl_block_accel_if.sv
// FSL slave/master channel bundle for fsl_block_accel.
// The slave modport is the accelerator's view: it pops the slave FIFO and
// pushes the master FIFO. The master modport is the surrounding system.
interface fsl_block_accel_if #(
  parameter int C_DWIDTH = 32
);
  logic                FSL_S_Read;
  logic [0:C_DWIDTH-1] FSL_S_Data;
  logic                FSL_S_Control;
  logic                FSL_S_Exists;
  logic                FSL_M_Write;
  logic [0:C_DWIDTH-1] FSL_M_Data;
  logic                FSL_M_Control;
  logic                FSL_M_Full;

  modport slave (
    output FSL_S_Read,
    input  FSL_S_Data,
    input  FSL_S_Control,
    input  FSL_S_Exists,
    output FSL_M_Write,
    output FSL_M_Data,
    output FSL_M_Control,
    input  FSL_M_Full
  );

  modport master (
    input  FSL_S_Read,
    output FSL_S_Data,
    output FSL_S_Control,
    output FSL_S_Exists,
    input  FSL_M_Write,
    input  FSL_M_Data,
    input  FSL_M_Control,
    output FSL_M_Full
  );
endinterface

// File: rtl/fsl_block_accel.sv
// Block XOR accelerator on FSL. Collects C_BLOCK_WORDS data words, XORs each
// with the key word at the same position, then streams the block back out.
// Control words on the slave side load the key table round-robin.
// Optional feature: define FSL_BLOCK_ACCEL_CHAIN_EN to also XOR each word with
// the previous output block (chaining); any key write restarts the chain.
module fsl_block_accel #(
  parameter int C_DWIDTH      = 32,
  parameter int C_BLOCK_WORDS = 4
) (
  input  logic              FSL_Clk,
  input  logic              FSL_Rst,
  output logic              FSL_S_Clk,
  output logic              FSL_M_Clk,
  fsl_block_accel_if.slave  bus
);
  localparam int IW = (C_BLOCK_WORDS > 1) ? $clog2(C_BLOCK_WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(C_BLOCK_WORDS - 1);

  typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       widx, ridx, kidx;
  logic [0:C_DWIDTH-1] key     [C_BLOCK_WORDS];
  logic [0:C_DWIDTH-1] blk_buf [C_BLOCK_WORDS];
  logic [0:C_DWIDTH-1] enc_word;
  logic                s_read, m_write, m_control;
  logic [0:C_DWIDTH-1] m_data;
  logic                key_wr, data_wr, last_out;

  assign FSL_S_Clk = FSL_Clk;
  assign FSL_M_Clk = FSL_Clk;

  assign key_wr   = s_read && bus.FSL_S_Control;
  assign data_wr  = s_read && !bus.FSL_S_Control;
  assign last_out = m_write && (ridx == LAST);

`ifdef FSL_BLOCK_ACCEL_CHAIN_EN
  logic [0:C_DWIDTH-1] chain [C_BLOCK_WORDS];

  assign enc_word = bus.FSL_S_Data ^ key[widx] ^ chain[widx];

  // Chain register: cleared by any key write, reloaded with the finished block.
  always_ff @(posedge FSL_Clk) begin
    if (FSL_Rst || key_wr) begin
      for (int i = 0; i < C_BLOCK_WORDS; i++) chain[i] <= '0;
    end else if (last_out) begin
      for (int i = 0; i < C_BLOCK_WORDS; i++) chain[i] <= blk_buf[i];
    end
  end
`else
  assign enc_word = bus.FSL_S_Data ^ key[widx];
`endif

  // State register.
  always_ff @(posedge FSL_Clk) begin
    if (FSL_Rst) state_q <= COLLECT;
    else         state_q <= state_d;
  end

  // Next state: leave COLLECT on the last data word, leave EMIT on the last write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (data_wr && (widx == LAST)) state_d = EMIT;
      EMIT:    if (last_out)                  state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Handshake outputs; reset forces every strobe low in the same cycle.
  always_comb begin
    s_read    = 1'b0;
    m_write   = 1'b0;
    m_control = 1'b0;
    m_data    = blk_buf[ridx];
    if (!FSL_Rst) begin
      if (state_q == COLLECT) begin
        s_read = bus.FSL_S_Exists;
      end else begin
        m_write   = !bus.FSL_M_Full;
        m_control = (ridx == LAST);
      end
    end
  end

  assign bus.FSL_S_Read    = s_read;
  assign bus.FSL_M_Write   = m_write;
  assign bus.FSL_M_Data    = m_data;
  assign bus.FSL_M_Control = m_control;

  // Key table, block buffer and the three position counters.
  always_ff @(posedge FSL_Clk) begin
    if (FSL_Rst) begin
      widx <= '0;
      ridx <= '0;
      kidx <= '0;
      for (int i = 0; i < C_BLOCK_WORDS; i++) begin
        key[i]     <= '0;
        blk_buf[i] <= '0;
      end
    end else begin
      if (key_wr) begin
        key[kidx] <= bus.FSL_S_Data;
        kidx      <= kidx + IW'(1);
      end
      if (data_wr) begin
        blk_buf[widx] <= enc_word;
        widx          <= widx + IW'(1);
      end
      if (m_write) ridx <= ridx + IW'(1);
    end
  end
endmodule

// File: tb/tb_fsl_block_accel.sv
// Self-checking bench for fsl_block_accel (C_DWIDTH=32, C_BLOCK_WORDS=4).
// A block-level reference model predicts outputs from queued stimulus words.
module tb_fsl_block_accel;
  localparam int DW = 32;
  localparam int BW = 4;

  typedef struct packed { logic ctrl; logic [DW-1:0] data; } stim_t;
  typedef struct packed { logic [DW-1:0] data; logic last; } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_clk, m_clk;

  fsl_block_accel_if #(.C_DWIDTH(DW)) bus ();

  fsl_block_accel #(.C_DWIDTH(DW), .C_BLOCK_WORDS(BW)) dut (
    .FSL_Clk   (clk),
    .FSL_Rst   (rst),
    .FSL_S_Clk (s_clk),
    .FSL_M_Clk (m_clk),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int p_exists = 100;
  int p_full   = 0;

  stim_t stim_q[$];
  out_t  pend_q[$];
  out_t  out_q[$];
  bit    full_q[$];

  // Reference model state: key table, next key slot, partial block, chain.
  logic [DW-1:0] mkey   [BW];
  logic [DW-1:0] mchain [BW];
  logic [DW-1:0] mblk   [$];
  int            mkidx;

  function automatic void model_reset();
    for (int i = 0; i < BW; i++) begin
      mkey[i]   = '0;
      mchain[i] = '0;
    end
    mkidx = 0;
    mblk.delete();
    pend_q.delete();
  endfunction

  function automatic void model_consume(input stim_t s);
    logic [DW-1:0] v;
    if (s.ctrl) begin
      mkey[mkidx] = s.data;
      mkidx = (mkidx + 1) % BW;
`ifdef FSL_BLOCK_ACCEL_CHAIN_EN
      for (int i = 0; i < BW; i++) mchain[i] = '0;
`endif
    end else begin
      v = s.data ^ mkey[mblk.size()];
`ifdef FSL_BLOCK_ACCEL_CHAIN_EN
      v = v ^ mchain[mblk.size()];
`endif
      mblk.push_back(v);
      if (mblk.size() == BW) begin
        for (int i = 0; i < BW; i++) begin
          pend_q.push_back('{data: mblk[i], last: (i == BW - 1)});
`ifdef FSL_BLOCK_ACCEL_CHAIN_EN
          mchain[i] = mblk[i];
`endif
        end
        mblk.delete();
      end
    end
  endfunction

  function automatic void push_word(input logic ctrl, input logic [DW-1:0] d);
    stim_q.push_back('{ctrl: ctrl, data: d});
  endfunction

  // Runs cycles until stimulus and pending output drain (or max_writes reached),
  // checking every handshake output against the model each cycle.
  task automatic run_engine(input int max_writes, input int budget);
    int  writes = 0;
    int  cyc = 0;
    bit  e_read, e_write, e_ctl;
    forever begin
      if (stim_q.size() == 0 && pend_q.size() == 0) break;
      if (max_writes >= 0 && writes >= max_writes) break;
      n_total++;
      if (cyc >= budget) begin
        $display("FAIL engine_timeout: cycles=%0d stim_left=%0d pend_left=%0d", cyc, stim_q.size(), pend_q.size());
        break;
      end
      n_pass++;
      if (stim_q.size() > 0 && $urandom_range(99) < p_exists) begin
        bus.FSL_S_Exists  = 1'b1;
        bus.FSL_S_Data    = stim_q[0].data;
        bus.FSL_S_Control = stim_q[0].ctrl;
      end else begin
        bus.FSL_S_Exists  = 1'b0;
        bus.FSL_S_Data    = $urandom;
        bus.FSL_S_Control = 1'($urandom);
      end
      if (full_q.size() > 0) bus.FSL_M_Full = full_q.pop_front();
      else                   bus.FSL_M_Full = ($urandom_range(99) < p_full);
      #1;
      e_read  = bus.FSL_S_Exists && (pend_q.size() == 0);
      e_write = (pend_q.size() > 0) && !bus.FSL_M_Full;
      e_ctl   = (pend_q.size() > 0) && pend_q[0].last;
      n_total++;
      if (bus.FSL_S_Read !== e_read) $display("FAIL s_read cyc=%0d: got %b want %b", cyc, bus.FSL_S_Read, e_read);
      else n_pass++;
      n_total++;
      if (bus.FSL_M_Write !== e_write) $display("FAIL m_write cyc=%0d: got %b want %b", cyc, bus.FSL_M_Write, e_write);
      else n_pass++;
      n_total++;
      if (bus.FSL_M_Control !== e_ctl) $display("FAIL m_control cyc=%0d: got %b want %b", cyc, bus.FSL_M_Control, e_ctl);
      else n_pass++;
      if (pend_q.size() > 0) begin
        n_total++;
        if (bus.FSL_M_Data !== pend_q[0].data)
          $display("FAIL m_data cyc=%0d: got %h want %h", cyc, bus.FSL_M_Data, pend_q[0].data);
        else n_pass++;
      end
      if (bus.FSL_M_Write === 1'b1) begin
        out_q.push_back('{data: bus.FSL_M_Data, last: bus.FSL_M_Control});
        writes++;
      end
      if (e_read) model_consume(stim_q.pop_front());
      if (e_write) void'(pend_q.pop_front());
      @(posedge clk); #1;
      cyc++;
    end
    bus.FSL_S_Exists = 1'b0;
    bus.FSL_M_Full   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.FSL_S_Exists = 1'b1;
    bus.FSL_M_Full   = 1'b0;
    bus.FSL_S_Data   = $urandom;
    bus.FSL_S_Control = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.FSL_S_Exists = 1'b0;
    stim_q.delete();
    full_q.delete();
    out_q.delete();
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.FSL_S_Exists = 1'b1;
    bus.FSL_M_Full   = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (bus.FSL_S_Read !== 1'b0) $display("FAIL reset_s_read: got %b want 0", bus.FSL_S_Read); else n_pass++;
    n_total++;
    if (bus.FSL_M_Write !== 1'b0) $display("FAIL reset_m_write: got %b want 0", bus.FSL_M_Write); else n_pass++;
    n_total++;
    if (bus.FSL_M_Control !== 1'b0) $display("FAIL reset_m_control: got %b want 0", bus.FSL_M_Control); else n_pass++;
    n_total++;
    if (s_clk !== clk || m_clk !== clk) $display("FAIL fsl_clk_fwd: got %b/%b want %b", s_clk, m_clk, clk); else n_pass++;
    do_reset();
    bus.FSL_S_Exists = 1'b1;
    #1;
    n_total++;
    if (bus.FSL_S_Read !== 1'b1) $display("FAIL collect_s_read: got %b want 1", bus.FSL_S_Read); else n_pass++;
    bus.FSL_S_Exists = 1'b0;
    #1;
    n_total++;
    if (bus.FSL_S_Read !== 1'b0) $display("FAIL collect_s_read_idle: got %b want 0", bus.FSL_S_Read); else n_pass++;
  endtask

  task automatic test_basic();
    do_reset();
    p_exists = 100; p_full = 0;
    for (int i = 1; i <= 4; i++) push_word(1'b1, DW'(i));
    for (int i = 1; i <= 4; i++) push_word(1'b0, DW'(i * 16));
    run_engine(-1, 100);
    n_total++;
    if (out_q.size() != 4) $display("FAIL basic_count: got %0d want 4", out_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (out_q[i].data !== DW'(17 * (i + 1)) || out_q[i].last !== (i == 3))
          $display("FAIL basic_word%0d: got %h/%b want %h/%b", i, out_q[i].data, out_q[i].last, DW'(17 * (i + 1)), (i == 3));
        else n_pass++;
      end
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    p_exists = 100; p_full = 0;
    for (int i = 1; i <= 4; i++) push_word(1'b1, DW'(i));
    run_engine(-1, 50);
    for (int i = 1; i <= 4; i++) push_word(1'b0, DW'(i * 16));
    for (int i = 0; i < 5; i++) full_q.push_back(1'b0);
    for (int i = 0; i < 5; i++) full_q.push_back(1'b1);
    run_engine(-1, 100);
    n_total++;
    if (out_q.size() != 4) $display("FAIL stall_count: got %0d want 4", out_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (out_q[i].data !== DW'(17 * (i + 1)))
          $display("FAIL stall_word%0d: got %h want %h", i, out_q[i].data, DW'(17 * (i + 1)));
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    p_exists = 100; p_full = 0;
    for (int i = 0; i < 4; i++) push_word(1'b1, $urandom);
    for (int i = 0; i < 8; i++) push_word(1'b0, $urandom);
    run_engine(-1, 100);
    n_total++;
    if (out_q.size() != 8) $display("FAIL b2b_count: got %0d want 8", out_q.size()); else n_pass++;
  endtask

  task automatic test_key_midblock();
    logic [DW-1:0] d [8];
    logic [DW-1:0] e [8];
    do_reset();
    p_exists = 80; p_full = 20;
    for (int i = 0; i < 8; i++) d[i] = $urandom;
    push_word(1'b0, d[0]); push_word(1'b0, d[1]);
    push_word(1'b1, 32'hFF);
    for (int i = 2; i < 8; i++) push_word(1'b0, d[i]);
    for (int i = 0; i < 4; i++) e[i] = d[i];
    e[4] = d[4] ^ 32'hFF;
    for (int i = 5; i < 8; i++) e[i] = d[i];
`ifdef FSL_BLOCK_ACCEL_CHAIN_EN
    for (int i = 4; i < 8; i++) e[i] = e[i] ^ d[i - 4];
`endif
    run_engine(-1, 200);
    n_total++;
    if (out_q.size() != 8) $display("FAIL midkey_count: got %0d want 8", out_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 8; i++) begin
        n_total++;
        if (out_q[i].data !== e[i]) $display("FAIL midkey_word%0d: got %h want %h", i, out_q[i].data, e[i]);
        else n_pass++;
      end
    end
  endtask

`ifdef FSL_BLOCK_ACCEL_CHAIN_EN
  task automatic test_chain();
    do_reset();
    p_exists = 100; p_full = 0;
    for (int b = 0; b < 2; b++)
      for (int i = 1; i <= 4; i++) push_word(1'b0, DW'(i));
    push_word(1'b1, 32'h0);
    for (int i = 1; i <= 4; i++) push_word(1'b0, DW'(i));
    run_engine(-1, 200);
    n_total++;
    if (out_q.size() != 12) $display("FAIL chain_count: got %0d want 12", out_q.size());
    else begin
      n_pass++;
      for (int i = 4; i < 12; i++) begin
        n_total++;
        if (out_q[i].data !== ((i < 8) ? DW'(0) : DW'(i - 7)))
          $display("FAIL chain_word%0d: got %h want %h", i, out_q[i].data, (i < 8) ? DW'(0) : DW'(i - 7));
        else n_pass++;
      end
    end
  endtask
`endif

  task automatic test_reset_midemit();
    logic [DW-1:0] d [4];
    do_reset();
    p_exists = 100; p_full = 0;
    for (int i = 0; i < 4; i++) push_word(1'b1, $urandom | 32'h1);
    for (int i = 0; i < 4; i++) push_word(1'b0, $urandom);
    run_engine(2, 100);
    rst = 1'b1;
    #1;
    n_total++;
    if (bus.FSL_M_Write !== 1'b0) $display("FAIL rst_midemit_write: got %b want 0", bus.FSL_M_Write); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    stim_q.delete();
    out_q.delete();
    model_reset();
    n_total++;
    if (bus.FSL_M_Write !== 1'b0) $display("FAIL post_rst_write: got %b want 0", bus.FSL_M_Write); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      d[i] = $urandom;
      push_word(1'b0, d[i]);
    end
    run_engine(-1, 100);
    n_total++;
    if (out_q.size() != 4) $display("FAIL post_rst_count: got %0d want 4", out_q.size());
    else begin
      n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (out_q[i].data !== d[i]) $display("FAIL post_rst_word%0d: got %h want %h", i, out_q[i].data, d[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    p_exists = 70; p_full = 30;
    for (int i = 0; i < 4; i++) push_word(1'b1, $urandom);
    for (int i = 0; i < 6 * BW; i++) begin
      if ($urandom_range(99) < 20) push_word(1'b1, $urandom);
      push_word(1'b0, $urandom);
    end
    run_engine(-1, 2000);
    n_total++;
    if (out_q.size() != 6 * BW) $display("FAIL random_count: got %0d want %0d", out_q.size(), 6 * BW); else n_pass++;
  endtask

  initial begin
    bus.FSL_S_Exists  = 1'b0;
    bus.FSL_S_Data    = '0;
    bus.FSL_S_Control = 1'b0;
    bus.FSL_M_Full    = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_full_stall();
    test_back_to_back();
    test_key_midblock();
`ifdef FSL_BLOCK_ACCEL_CHAIN_EN
    test_chain();
`endif
    test_reset_midemit();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
